// File: rtl/fpga_rst_seq_if.sv
// Board-side signal bundle for the FPGA reset sequencer.
//   slave  modport : sequencer side (takes the raw requests/status, drives the resets)
//   master modport : board/testbench side
// Members:
//   btn_rst_i     raw reset button, active-high, asynchronous
//   vio_rst_i     VIO reset request, active-high, synchronous to clk_i
//   mmcm_locked_i clock wizard locked, asynchronous
//   calib_done_i  DRAM calibration complete, asynchronous
//   boot_mode_i   boot mode selection
//   ddr_rst_o     active-high DRAM controller reset
//   soc_rst_no    active-low SoC reset
//   boot_mode_o   boot mode latched at SoC reset release
//   calib_err_o   calibration timed out
//   state_o       current FSM state encoding (debug)
interface fpga_rst_seq_if;
  logic       btn_rst_i;
  logic       vio_rst_i;
  logic       mmcm_locked_i;
  logic       calib_done_i;
  logic [1:0] boot_mode_i;
  logic       ddr_rst_o;
  logic       soc_rst_no;
  logic [1:0] boot_mode_o;
  logic       calib_err_o;
  logic [2:0] state_o;

  modport slave (
    input  btn_rst_i, vio_rst_i, mmcm_locked_i, calib_done_i, boot_mode_i,
    output ddr_rst_o, soc_rst_no, boot_mode_o, calib_err_o, state_o
  );

  modport master (
    output btn_rst_i, vio_rst_i, mmcm_locked_i, calib_done_i, boot_mode_i,
    input  ddr_rst_o, soc_rst_no, boot_mode_o, calib_err_o, state_o
  );
endinterface

// File: rtl/fpga_rst_seq.sv
// FPGA reset sequencer: releases the DRAM controller once the clock wizard is
// locked, waits for DRAM calibration (with timeout), holds the SoC in reset for
// a few more cycles, then releases it. Button/VIO requests restart the sequence.
// Ports:
//   clk_i   single clock (soc_clk domain)
//   rst_ni  synchronous active-low reset
//   bus     fpga_rst_seq_if.slave (requests, status, resets, boot mode, debug)
module fpga_rst_seq #(
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned HoldCycles     = 16,
  parameter int unsigned CalibTimeout   = 50_000_000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fpga_rst_seq_if.slave bus
);

  localparam logic [2:0] ST_RST        = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] ST_WAIT_CALIB = 3'd2;
  localparam logic [2:0] ST_HOLD       = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;
  localparam logic [2:0] ST_FAIL       = 3'd5;

  // Terminal counts; zero-cycle debounce/hold degenerate to one cycle.
  localparam logic [31:0] DbLast    = (DebounceCycles == 0) ? 32'd0 : 32'(DebounceCycles - 1);
  localparam logic [31:0] HoldLast  = (HoldCycles == 0)     ? 32'd0 : 32'(HoldCycles - 1);
  localparam logic [31:0] CalibLast = (CalibTimeout == 0)   ? 32'd0 : 32'(CalibTimeout - 1);
  localparam logic        CalibEn   = (CalibTimeout != 0);

  // Synchronizer bit order: {btn, locked, calib}
  logic [2:0]  r_sync_s1;
  logic [2:0]  r_sync_s2;
  logic        r_db_level;
  logic [31:0] r_db_cnt;
  logic [2:0]  r_state;
  logic [31:0] r_cnt;
  logic        r_ddr_rst;
  logic        r_soc_rst_n;
  logic [1:0]  r_boot_mode;
  logic        r_calib_err;

  logic        w_btn;
  logic        w_locked;
  logic        w_calib;
  logic        w_rreq;
  logic        w_needs_lock;
  logic [2:0]  w_next;

  assign w_btn    = r_sync_s2[2];
  assign w_locked = r_sync_s2[1];
  assign w_calib  = r_sync_s2[0];
  assign w_rreq   = r_db_level | bus.vio_rst_i;

  assign w_needs_lock = (r_state == ST_WAIT_CALIB) || (r_state == ST_HOLD) ||
                        (r_state == ST_RUN)        || (r_state == ST_FAIL);

  // Priority: reset request, then lock loss, then per-state progress.
  always_comb begin
    w_next = r_state;
    if ((r_state != ST_RST) && w_rreq) begin
      w_next = ST_RST;
    end else if (w_needs_lock && !w_locked) begin
      w_next = ST_WAIT_LOCK;
    end else begin
      case (r_state)
        ST_RST:       w_next = ST_WAIT_LOCK;
        ST_WAIT_LOCK: if (w_locked) w_next = ST_WAIT_CALIB;
        ST_WAIT_CALIB: begin
          if (w_calib)                             w_next = ST_HOLD;
          else if (CalibEn && (r_cnt == CalibLast)) w_next = ST_FAIL;
        end
        ST_HOLD: begin
          if (!w_calib)                w_next = ST_WAIT_CALIB;
          else if (r_cnt == HoldLast)  w_next = ST_RUN;
        end
        ST_RUN:       if (!w_calib) w_next = ST_WAIT_CALIB;
        ST_FAIL:      w_next = ST_FAIL;
        default:      w_next = ST_RST;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync_s1   <= '0;
      r_sync_s2   <= '0;
      r_db_level  <= 1'b0;
      r_db_cnt    <= '0;
      r_state     <= ST_RST;
      r_cnt       <= '0;
      r_ddr_rst   <= 1'b1;
      r_soc_rst_n <= 1'b0;
      r_boot_mode <= 2'b00;
      r_calib_err <= 1'b0;
    end else begin
      r_sync_s1 <= {bus.btn_rst_i, bus.mmcm_locked_i, bus.calib_done_i};
      r_sync_s2 <= r_sync_s1;

      // Accept a new button level only after DebounceCycles consecutive differing samples.
      if (w_btn != r_db_level) begin
        if (r_db_cnt == DbLast) begin
          r_db_level <= w_btn;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 32'd1;
        end
      end else begin
        r_db_cnt <= '0;
      end

      r_state <= w_next;
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + 32'd1;

      // ddr/err follow the state they are registered with; soc release lags
      // entry into RUN by one cycle but drops together with leaving RUN.
      r_ddr_rst   <= (w_next == ST_RST) || (w_next == ST_WAIT_LOCK);
      r_soc_rst_n <= (r_state == ST_RUN) && (w_next == ST_RUN);
      r_calib_err <= (w_next == ST_FAIL);
      if ((r_state == ST_HOLD) && (w_next == ST_RUN)) r_boot_mode <= bus.boot_mode_i;
    end
  end

  assign bus.ddr_rst_o   = r_ddr_rst;
  assign bus.soc_rst_no  = r_soc_rst_n;
  assign bus.boot_mode_o = r_boot_mode;
  assign bus.calib_err_o = r_calib_err;
  assign bus.state_o     = r_state;

endmodule
